// File: rtl/caravel_wb_responder_pkg.sv
// Shared types and constants for the Caravel Wishbone responder.
package caravel_wb_responder_pkg;

    localparam int unsigned CARAVEL_ADR_W = 28;
    localparam int unsigned WB_DATA_W     = 32;
    localparam int unsigned WB_SEL_W      = 4;

    // One buffered bus request, as captured at acceptance.
    typedef struct packed {
        logic                     we;
        logic [WB_SEL_W-1:0]      sel;
        logic [CARAVEL_ADR_W-1:0] adr;
        logic [WB_DATA_W-1:0]     data;
    } wb_req_t;

    localparam int unsigned WB_REQ_W = $bits(wb_req_t);

    // Response sequencer states: one memory op outstanding at a time.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/caravel_wb_responder_fifo.sv
// Request buffer: synchronous FIFO with push/pop/flush and async reset.
module wb_request_fifo
    import caravel_wb_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  wb_req_t push_data_i,
    input  logic    pop_i,
    input  logic    flush_i,
    output wb_req_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_req_t            store_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok_c;
    logic               pop_ok_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_o    = store_q[rd_ptr_q];
    assign push_ok_c = push_i && !full_o && !flush_i;
    assign pop_ok_c  = pop_i && !empty_o && !flush_i;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk_i) begin
        if (push_ok_c) store_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/caravel_wb_responder.sv
// Pipelined Wishbone B4 responder: buffers requests, serialises them to a
// fixed-latency word memory, and returns in-order ack/error with read data.
module caravel_wb_responder
    import caravel_wb_responder_pkg::*;
#(
    parameter int unsigned              MEM_ADDR_WIDTH = 10,
    parameter logic [CARAVEL_ADR_W-1:0] BASE_TAG       = '0,
    parameter int unsigned              READ_LATENCY   = 1,
    parameter int unsigned              FIFO_DEPTH     = 2
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [WB_SEL_W-1:0]       wb_sel_i,
    input  logic [WB_DATA_W-1:0]      wb_data_i,
    input  logic [CARAVEL_ADR_W-1:0]  wb_adr_i,
    output logic                      wb_ack_o,
    output logic                      wb_stall_o,
    output logic                      wb_error_o,
    output logic [WB_DATA_W-1:0]      wb_data_o,
    output logic                      mem_en_o,
    output logic [WB_SEL_W-1:0]       mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WB_DATA_W-1:0]      mem_wdata_o,
    input  logic [WB_DATA_W-1:0]      mem_rdata_i
);

    localparam int unsigned TAG_LSB = MEM_ADDR_WIDTH + 2;
    localparam int unsigned TAG_W   = CARAVEL_ADR_W - TAG_LSB;
    localparam int unsigned LAT_W   = $clog2(READ_LATENCY + 1);

    wb_req_t            push_req_c;
    wb_req_t            head_c;
    logic               accept_c;
    logic               flush_c;
    logic               pop_c;
    logic               fifo_full;
    logic               fifo_empty;
    logic               head_mapped_c;

    rsp_state_e         state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [WB_DATA_W-1:0] data_q, data_d;

    // Stall comes straight from the registered occupancy, so a same-cycle pop never unstalls.
    assign wb_stall_o = fifo_full;
    assign accept_c   = wb_cyc_i && wb_stb_i && !fifo_full;
    assign flush_c    = !wb_cyc_i;
    assign push_req_c = '{we: wb_we_i, sel: wb_sel_i, adr: wb_adr_i, data: wb_data_i};

    // Window decode: tag bits must match and the address must be word aligned.
    assign head_mapped_c = (head_c.adr[CARAVEL_ADR_W-1:TAG_LSB] == BASE_TAG[TAG_W-1:0])
                        && (head_c.adr[1:0] == 2'b00);

    wb_request_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .push_i      (accept_c),
        .push_data_i (push_req_c),
        .pop_i       (pop_c),
        .flush_i     (flush_c),
        .head_o      (head_c),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Sequencer next state and qualified memory/bus strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        err_d       = err_q;
        data_d      = data_q;
        pop_c       = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        wb_ack_o    = 1'b0;
        wb_error_o  = 1'b0;
        wb_data_o   = '0;

        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && !fifo_empty) begin
                    pop_c  = 1'b1;
                    we_d   = head_c.we;
                    data_d = '0;
                    if (head_mapped_c) begin
                        mem_en_o    = 1'b1;
                        mem_we_o    = head_c.we ? head_c.sel : '0;
                        mem_addr_o  = head_c.adr[MEM_ADDR_WIDTH+1:2];
                        mem_wdata_o = head_c.we ? head_c.data : '0;
                        cnt_d       = LAT_W'(READ_LATENCY);
                        err_d       = 1'b0;
                        state_d     = ST_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    // Bus cycle abandoned: the memory op finishes on its own, no response.
                    state_d = ST_IDLE;
                end else if (cnt_q == LAT_W'(1)) begin
                    data_d  = we_q ? '0 : mem_rdata_i;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (wb_cyc_i) begin
                    wb_ack_o   = !err_q;
                    wb_error_o = err_q;
                    wb_data_o  = err_q ? '0 : data_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset abandons any in-flight request.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_caravel_wb_responder.sv
// Directed bench for caravel_wb_responder with a response scoreboard.
module tb_caravel_wb_responder;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_data_i;
    logic [27:0] wb_adr_i;
    logic        wb_ack_o;
    logic        wb_stall_o;
    logic        wb_error_o;
    logic [31:0] wb_data_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int          checks;
    int          errors;
    bit          started;
    bit          stall_seen;
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;
    logic [31:0] dev_mem [1024];
    logic [31:0] ref_mem [1024];

    caravel_wb_responder dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_data_i   (wb_data_i),
        .wb_adr_i    (wb_adr_i),
        .wb_ack_o    (wb_ack_o),
        .wb_stall_o  (wb_stall_o),
        .wb_error_o  (wb_error_o),
        .wb_data_o   (wb_data_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // One-cycle-latency word memory with byte write enables.
    always @(posedge wb_clk_i) begin
        if (mem_en_o) begin
            mem_rdata_i <= dev_mem[mem_addr_o];
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) dev_mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bmapped(input logic [27:0] a);
        return (a[27:12] == 16'h0) && (a[1:0] == 2'b00);
    endfunction

    // Response monitor: pops the scoreboard on every ack/error.
    always @(negedge wb_clk_i) begin
        if (started && !wb_rst_i) begin
            if (wb_stall_o) stall_seen = 1'b1;
            chk("ack_err_exclusive", 32'(wb_ack_o & wb_error_o), 32'd0);
            if (wb_ack_o || wb_error_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_error_flag", 32'(wb_error_o), 32'(mon_e[32]));
                    chk("rsp_data", wb_data_o, mon_e[31:0]);
                end
            end else begin
                chk("idle_rdata_zero", wb_data_o, 32'd0);
            end
            if (!mem_en_o)
                chk("idle_mem_zero", 32'(|{mem_we_o, mem_addr_o, mem_wdata_o}), 32'd0);
        end
    end

    // Present one request and wait (bounded) for acceptance; model the expected response.
    task automatic do_req(input logic we, input logic [3:0] sel, input logic [27:0] adr,
                          input logic [31:0] data, input bit hold, input bit expect_rsp);
        bit acc;
        bit m;
        acc = 1'b0;
        m   = bmapped(adr);
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = we;
        wb_sel_i  = sel;
        wb_adr_i  = adr;
        wb_data_i = data;
        for (int n = 0; n < 50; n++) begin
            @(negedge wb_clk_i);
            if (!wb_stall_o) begin
                acc = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        if (acc && expect_rsp) begin
            if (!m)      exp_q.push_back({1'b1, 32'd0});
            else if (we) exp_q.push_back({1'b0, 32'd0});
            else         exp_q.push_back({1'b0, ref_mem[adr[11:2]]});
        end
        if (acc && m && we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[11:2]][8*b +: 8] = data[8*b +: 8];
        @(posedge wb_clk_i);
        #1;
        if (!hold) wb_stb_i = 1'b0;
    endtask

    // Single request with cycle-exact checks of memory strobe and response timing.
    task automatic timed_req(input logic we, input logic [3:0] sel, input logic [27:0] adr,
                             input logic [31:0] data);
        bit m;
        m = bmapped(adr);
        do_req(we, sel, adr, data, 1'b0, 1'b1);
        @(negedge wb_clk_i);
        chk("t1_mem_en", 32'(mem_en_o), 32'(m));
        if (m) begin
            chk("t1_mem_addr", 32'(mem_addr_o), 32'(adr[11:2]));
            chk("t1_mem_we", 32'(mem_we_o), 32'(we ? sel : 4'd0));
            if (we) chk("t1_mem_wdata", mem_wdata_o, data);
        end
        @(negedge wb_clk_i);
        chk("t2_error", 32'(wb_error_o), 32'(!m));
        chk("t2_ack", 32'(wb_ack_o), 32'd0);
        chk("t2_mem_en", 32'(mem_en_o), 32'd0);
        if (m) begin
            @(negedge wb_clk_i);
            chk("t3_ack", 32'(wb_ack_o), 32'd1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge wb_clk_i);
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        started    = 1'b0;
        stall_seen = 1'b0;
        wb_rst_i   = 1'b1;
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        wb_we_i    = 1'b0;
        wb_sel_i   = 4'h0;
        wb_data_i  = 32'h0;
        wb_adr_i   = 28'h0;
        for (int i = 0; i < 1024; i++) begin
            dev_mem[i] = $urandom;
            ref_mem[i] = dev_mem[i];
        end
        dev_mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        dev_mem[2] = 32'h11223344;
        ref_mem[2] = 32'h11223344;

        // Reset state
        idle(3);
        chk("rst_bus_outputs", 32'({wb_ack_o, wb_error_o, wb_stall_o}), 32'd0);
        chk("rst_rdata", wb_data_o, 32'd0);
        chk("rst_mem_outputs", 32'(|{mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'd0);
        wb_rst_i = 1'b0;
        started  = 1'b1;
        wb_cyc_i = 1'b1;
        idle(2);

        // Single read of word 5, ack at T3, never stalled
        stall_seen = 1'b0;
        timed_req(1'b0, 4'hF, 28'h14, 32'h0);
        idle(2);
        chk("single_read_no_stall", 32'(stall_seen), 32'd0);

        // Byte-lane write to word 2, then readback
        timed_req(1'b1, 4'b0100, 28'h8, 32'h00AB0000);
        idle(2);
        timed_req(1'b0, 4'hF, 28'h8, 32'h0);
        idle(2);
        chk("byte_write_model", ref_mem[2], 32'h11AB3344);

        // Four back-to-back reads with strobe held
        stall_seen = 1'b0;
        for (int i = 0; i < 4; i++)
            do_req(1'b0, 4'hF, 28'h40 + 28'(4 * i), 32'h0, i < 3, 1'b1);
        drain();
        chk("burst_stall_seen", 32'(stall_seen), 32'd1);
        idle(2);

        // Unmapped tag, misaligned address, and zero-select write
        timed_req(1'b0, 4'hF, 28'h0001000, 32'h0);
        idle(2);
        timed_req(1'b0, 4'hF, 28'h2, 32'h0);
        idle(2);
        timed_req(1'b1, 4'h0, 28'h30, 32'h12345678);
        idle(2);

        // Drop cyc while a read is in WAIT with one more request queued
        do_req(1'b0, 4'hF, 28'h14, 32'h0, 1'b1, 1'b0);
        do_req(1'b0, 4'hF, 28'h18, 32'h0, 1'b0, 1'b0);
        wb_cyc_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b1;
        @(negedge wb_clk_i);
        chk("flush_no_mem_en", 32'(mem_en_o), 32'd0);
        chk("flush_not_stalled", 32'(wb_stall_o), 32'd0);
        idle(6);
        timed_req(1'b0, 4'hF, 28'h14, 32'h0);
        idle(2);

        // Asynchronous reset while a read is in WAIT
        do_req(1'b0, 4'hF, 28'h18, 32'h0, 1'b0, 1'b0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b1;
        #1;
        chk("async_rst_bus", 32'({wb_ack_o, wb_error_o, wb_stall_o}), 32'd0);
        chk("async_rst_rdata", wb_data_o, 32'd0);
        chk("async_rst_mem", 32'(|{mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'd0);
        idle(2);
        wb_rst_i = 1'b0;
        idle(6);
        timed_req(1'b0, 4'hF, 28'h8, 32'h0);
        idle(2);

        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
